// File: rtl/dc_offset_ctrl_pkg.sv
// Shared definitions for the AM demodulator DC-offset controller.
package dc_offset_ctrl_pkg;

  localparam int unsigned AMD_DATA_W = 12;

  typedef enum logic [1:0] {
    AMD_ST_IDLE   = 2'd0,
    AMD_ST_ACCUM  = 2'd1,
    AMD_ST_UPDATE = 2'd2,
    AMD_ST_RUN    = 2'd3
  } amd_state_e;

endpackage : dc_offset_ctrl_pkg

// File: rtl/dc_offset_ctrl_accum.sv
// Signed block accumulator with sample counter and last-sample flag.
module dc_accum #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned LOG2_N = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic [DATA_W-1:0]        i_data,
  output logic [DATA_W+LOG2_N-1:0] o_acc,
  output logic                     o_last_c
);

  localparam int unsigned ACC_W = DATA_W + LOG2_N;

  logic [ACC_W-1:0]  acc_d, acc_q;
  logic [LOG2_N-1:0] cnt_d, cnt_q;

  // Clear has priority over accumulate so a restart never counts its own sample.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (i_clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (i_en) begin
      acc_d = acc_q + {{LOG2_N{i_data[DATA_W-1]}}, i_data};
      cnt_d = cnt_q + LOG2_N'(1);
    end
  end

  // Accumulator and count registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_acc    = acc_q;
  assign o_last_c = (cnt_q == '1);

endmodule : dc_accum

// File: rtl/dc_offset_ctrl.sv
// DC-offset estimator and operand sequencer for the downstream registered subtractor.
module dc_offset_ctrl
  import dc_offset_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = AMD_DATA_W,
  parameter int unsigned LOG2_N     = 6,
  parameter int unsigned CONTINUOUS = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  input  logic              i_start,
  output logic [DATA_W-1:0] o_sub_a,
  output logic [DATA_W-1:0] o_sub_b,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_offset,
  output logic              o_busy,
  output logic              o_cal_done
);

  localparam int unsigned ACC_W = DATA_W + LOG2_N;

  amd_state_e        state_d, state_q;
  logic [DATA_W-1:0] offset_d, offset_q;
  logic              valid_d, valid_q;
  logic              busy_d, busy_q;
  logic              cal_done_d, cal_done_q;

  logic              acc_clr_c;
  logic              acc_en_c;
  logic              last_c;
  logic [ACC_W-1:0]  acc_c;
  logic signed [ACC_W-1:0] acc_s_c;
  logic signed [ACC_W-1:0] mean_c;

  dc_accum #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_accum (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (acc_clr_c),
    .i_en     (acc_en_c),
    .i_data   (i_data),
    .o_acc    (acc_c),
    .o_last_c (last_c)
  );

  // Block mean, floor rounding via arithmetic shift; always fits DATA_W.
  assign acc_s_c = signed'(acc_c);
  assign mean_c  = acc_s_c >>> LOG2_N;

  // State register plus registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= AMD_ST_IDLE;
      offset_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      cal_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      cal_done_q <= cal_done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      AMD_ST_IDLE:   if (i_start) state_d = AMD_ST_ACCUM;
      AMD_ST_ACCUM: begin
        if (i_start)                state_d = AMD_ST_ACCUM;
        else if (i_valid && last_c) state_d = AMD_ST_UPDATE;
      end
      AMD_ST_UPDATE: state_d = (CONTINUOUS != 0) ? AMD_ST_ACCUM : AMD_ST_RUN;
      AMD_ST_RUN:    if (i_start) state_d = AMD_ST_ACCUM;
      default:       state_d = AMD_ST_IDLE;
    endcase
  end

  // Output and datapath control; UPDATE ignores i_start and the sample it sees.
  always_comb begin
    acc_clr_c  = 1'b0;
    acc_en_c   = 1'b0;
    offset_d   = offset_q;
    cal_done_d = 1'b0;
    valid_d    = i_valid;
    busy_d     = (state_d == AMD_ST_ACCUM) || (state_d == AMD_ST_UPDATE);
    case (state_q)
      AMD_ST_IDLE,
      AMD_ST_RUN:    acc_clr_c = i_start;
      AMD_ST_ACCUM: begin
        acc_clr_c = i_start;
        acc_en_c  = i_valid & ~i_start;
      end
      AMD_ST_UPDATE: begin
        acc_clr_c  = 1'b1;
        offset_d   = DATA_W'(mean_c);
        cal_done_d = 1'b1;
      end
      default: acc_clr_c = 1'b1;
    endcase
  end

  assign o_sub_a    = i_data;
  assign o_sub_b    = offset_q;
  assign o_offset   = offset_q;
  assign o_valid    = valid_q;
  assign o_busy     = busy_q;
  assign o_cal_done = cal_done_q;

endmodule : dc_offset_ctrl

// File: tb/tb_dc_offset_ctrl.sv
// Directed bench for dc_offset_ctrl with the downstream subtractor modelled beside it.
module tb_dc_offset_ctrl;

  typedef struct {
    logic signed [11:0] a;
    logic signed [11:0] b;
    int                 period;
    logic signed [11:0] exp_off;
    logic signed [11:0] probe;
    logic signed [11:0] exp_sub;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [11:0] data;
  logic               valid;
  logic               start;

  logic signed [11:0] sub_a0, sub_b0, off0;
  logic               valid0, busy0, done0;
  logic signed [11:0] sub_a1, sub_b1, off1;
  logic               valid1, busy1, done1;
  logic signed [11:0] sub0_q;

  int n_cmp = 0;
  int n_err = 0;

  vec_t vecs [8];

  always #5 clk = ~clk;

  dc_offset_ctrl #(.DATA_W(12), .LOG2_N(4), .CONTINUOUS(0)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .i_start(start),
    .o_sub_a(sub_a0), .o_sub_b(sub_b0), .o_valid(valid0), .o_offset(off0),
    .o_busy(busy0), .o_cal_done(done0)
  );

  dc_offset_ctrl #(.DATA_W(12), .LOG2_N(4), .CONTINUOUS(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .i_start(start),
    .o_sub_a(sub_a1), .o_sub_b(sub_b1), .o_valid(valid1), .o_offset(off1),
    .o_busy(busy1), .o_cal_done(done1)
  );

  // Registered subtractor downstream of u0, wraps modulo 2^12.
  always_ff @(posedge clk) sub0_q <= sub_a0 - sub_b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int a, input int b, input int p,
                              input int eo, input int pr, input int es);
    vec_t v;
    v.a = 12'(a); v.b = 12'(b); v.period = p;
    v.exp_off = 12'(eo); v.probe = 12'(pr); v.exp_sub = 12'(es);
    return v;
  endfunction

  // Feed n valid samples of one value to u0 while it is accumulating.
  task automatic feed_const(input int n, input int value, input int old_off);
    for (int k = 0; k < n; k++) begin
      valid = 1'b1; data = 12'(value); start = 1'b0;
      @(negedge clk);
      chk("feed_busy", busy0, 1);
      chk("feed_done_early", done0, 0);
      chk("feed_off_hold", off0, old_off);
    end
  endtask

  // One full single-shot calibration on u0, then a datapath probe.
  task automatic run_cal(input vec_t v, input int old_off);
    int   nv;
    int   cyc;
    logic vin;
    @(negedge clk); start = 1'b1; valid = 1'b0;
    @(negedge clk); start = 1'b0;
    nv = 0; cyc = 0;
    while (nv < 16) begin
      vin   = ((cyc % v.period) == (v.period - 1));
      valid = vin;
      data  = ((nv % 2) == 0) ? v.a : v.b;
      if (vin) nv++;
      cyc++;
      @(negedge clk);
      chk("cal_busy", busy0, 1);
      chk("cal_done_early", done0, 0);
      chk("cal_off_hold", off0, old_off);
      chk("cal_valid_align", valid0, vin);
    end
    // UPDATE cycle: this sample must not reach the estimate.
    valid = 1'b1; data = 12'sd999;
    @(negedge clk);
    chk("cal_done", done0, 1);
    chk("cal_offset", off0, v.exp_off);
    chk("cal_busy_off", busy0, 0);
    valid = 1'b1; data = v.probe;
    #1;
    chk("sub_a_pass", sub_a0, v.probe);
    @(negedge clk);
    chk("done_pulse_end", done0, 0);
    chk("sub_result", sub0_q, v.exp_sub);
    chk("sub_valid", valid0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(100,   100,   1, 100,   100,   0);
    vecs[1] = mk(-37,   -37,   1, -37,   -37,   0);
    vecs[2] = mk(0,     1,     1, 0,     1,     1);
    vecs[3] = mk(-1,    0,     1, -1,    2047,  -2048);
    vecs[4] = mk(5,     5,     3, 5,     0,     -5);
    vecs[5] = mk(3,     4,     2, 3,     -2048, 2045);
    vecs[6] = mk(2047,  2047,  1, 2047,  -2048, 1);
    vecs[7] = mk(-2048, -2048, 1, -2048, 0,     -2048);

    rst_n = 1'b0; data = '0; valid = 1'b1; start = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_offset", off0, 0);
    chk("rst_sub_b", sub_b0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_done", done0, 0);
    chk("rst_busy_c", busy1, 0);
    rst_n = 1'b1; valid = 1'b0;

    // Table-driven calibrations.
    for (int i = 0; i < 8; i++) begin
      run_cal(vecs[i], (i == 0) ? 0 : int'(vecs[i-1].exp_off));
    end

    // Restart after 7 samples: count restarts, old offset (-2048) held.
    @(negedge clk); start = 1'b1; valid = 1'b0;
    @(negedge clk); start = 1'b0;
    feed_const(7, 50, -2048);
    start = 1'b1; valid = 1'b1; data = 12'sd50;
    @(negedge clk);
    chk("restart_busy", busy0, 1);
    chk("restart_off_hold", off0, -2048);
    feed_const(16, 60, -2048);
    valid = 1'b0;
    @(negedge clk);
    chk("restart_done", done0, 1);
    chk("restart_offset", off0, 60);

    // Reset for one cycle mid-accumulation.
    @(negedge clk); start = 1'b1; valid = 1'b0;
    @(negedge clk); start = 1'b0;
    feed_const(5, 7, 60);
    rst_n = 1'b0; valid = 1'b1; data = 12'sd7;
    @(negedge clk);
    chk("midrst_busy", busy0, 0);
    chk("midrst_offset", off0, 0);
    chk("midrst_valid", valid0, 0);
    chk("midrst_done", done0, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      valid = 1'b1; data = 12'sd7;
      @(negedge clk);
      chk("postrst_done", done0, 0);
      chk("postrst_busy", busy0, 0);
      chk("postrst_off", off0, 0);
    end

    // Continuous mode: 10 then 20, UPDATE every 17 cycles.
    rst_n = 1'b0; valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 34; c++) begin
      valid = 1'b1; data = (c < 17) ? 12'sd10 : 12'sd20;
      @(negedge clk);
      chk("cont_done", done1, ((c == 16) || (c == 33)) ? 1 : 0);
      chk("cont_offset", off1, (c >= 33) ? 20 : ((c >= 16) ? 10 : 0));
      chk("cont_sub_b", sub_b1, (c >= 33) ? 20 : ((c >= 16) ? 10 : 0));
      chk("cont_busy", busy1, 1);
      chk("cont_valid", valid1, 1);
    end
    chk("cont_sub_a", sub_a1, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_dc_offset_ctrl
